// File: rtl/nexpo_bus_pkg.sv
// Shared bus definitions for the nexpo memory path: read-owner encoding,
// word geometry and the RAM address range check.
package nexpo_bus_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int unsigned WORD_BYTES = 4;

  // True when every byte-address bit above the RAM word index is zero.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + $clog2(WORD_BYTES));
    return (hi == 32'd0);
  endfunction

endpackage

// File: rtl/nexpo_starve_arb.sv
// Two-requester fixed-priority arbiter: req[0] normally wins, but req[1] is
// forced through after STARVE_MAX consecutive denied cycles.
module nexpo_starve_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_lo;

  always_comb begin
    force_lo = (cnt_q == CNT_W'(STARVE_MAX));
    gnt      = '0;
    if (!rst) begin
      gnt[0] = req[0] & ~force_lo;
      gnt[1] = req[1] & (~req[0] | force_lo);
    end
    // Counts only denied cycles of a live low-priority request; saturates.
    cnt_d = cnt_q;
    if (!req[1] || gnt[1]) begin
      cnt_d = '0;
    end else if (!force_lo) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nexpo_mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports of
// the core; out-of-range accesses are granted but never strobe the RAM.
module nexpo_mem_arbiter
  import nexpo_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_mask,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  logic [1:0] gnt;
  logic       i_inr, d_inr;
  owner_e     state_q;
  logic       err_q;

  nexpo_starve_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req ({i_req, d_req}),
    .gnt (gnt)
  );

  assign d_gnt = gnt[0];
  assign i_gnt = gnt[1];
  assign i_inr = in_range(i_addr, ADDR_W);
  assign d_inr = in_range(d_addr, ADDR_W);

  always_comb begin
    m_en    = 1'b0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (d_gnt) begin
      m_addr = d_addr[ADDR_W+1:2];
      if (d_we) begin
        m_wdata = d_wdata;
        // An all-zero mask is a granted no-op rather than a RAM read.
        if (d_inr) begin
          m_we = d_mask;
          m_en = |d_mask;
        end
      end else begin
        m_en = d_inr;
      end
    end else if (i_gnt) begin
      m_addr = i_addr[ADDR_W+1:2];
      m_en   = i_inr;
    end
  end

  // Owner of the read launched this cycle; decided from the grant every cycle
  // so back-to-back reads stream without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else if (d_gnt && !d_we) begin
      state_q <= OWN_D;
      err_q   <= ~d_inr;
    end else if (i_gnt) begin
      state_q <= OWN_I;
      err_q   <= ~i_inr;
    end else begin
      state_q <= OWN_NONE;
      err_q   <= 1'b0;
    end
  end

  // Gating with rst discards a read that was in flight when reset arrived.
  assign i_rvalid = ~rst & (state_q == OWN_I);
  assign d_rvalid = ~rst & (state_q == OWN_D);
  assign i_err    = i_rvalid & err_q;
  assign i_rdata  = (i_rvalid && !err_q) ? m_rdata : '0;
  assign d_rdata  = (d_rvalid && !err_q) ? m_rdata : '0;
  assign d_err    = (d_rvalid & err_q) | (d_gnt & d_we & ~d_inr);

endmodule
